fetch_buffer: RTL

//  - Instruction fetch buffer between instruction memory and decode; feeds the decode-stage REG.
//  - FIFO of {pc, instruction} pairs that decouples fetch from decode stalls.
//  - Flush on branch/redirect discards all entries in one cycle.

---
 rtl/core101_pkg.sv | 14 +
 rtl/fetch_buffer_mem.sv | 28 ++
 rtl/fetch_buffer.sv | 103 ++++++++++
 3 files changed

// File: rtl/core101_pkg.sv
// Shared core definitions: machine word width, fetch entry layout and the NOP encoding.
package core101_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_mem.sv
// Fetch buffer storage: DEPTH words of {pc, instr}, synchronous write, asynchronous read, no reset.
module fetch_buffer_mem
    import core101_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                    clock_in,
    input  logic                    write_en,
    input  logic [PTR_WIDTH-1:0]    write_addr,
    input  logic [2*DATA_WIDTH-1:0] write_data,
    input  logic [PTR_WIDTH-1:0]    read_addr,
    output logic [2*DATA_WIDTH-1:0] read_data
);

    logic [2*DATA_WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clock_in) begin
        if (write_en) begin
            mem_reg[write_addr] <= write_data;
        end
    end

    // Combinational read keeps the head visible the cycle after it is written.
    assign read_data = mem_reg[read_addr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer between instruction memory and decode (first-word fall-through FIFO).
// Optional macro FETCH_BUFFER_BYPASS_EN lets a push into an empty buffer reach the outputs directly.
module fetch_buffer
    import core101_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  push_in,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic                  pop_in,
    input  logic                  flush_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  full_out,
    output logic                  empty_out,
    output logic [PTR_WIDTH:0]    count_out
);

    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

    logic [PTR_WIDTH-1:0]    rd_ptr_reg;
    logic [PTR_WIDTH-1:0]    wr_ptr_reg;
    logic [PTR_WIDTH:0]      count_reg;
    logic                    empty;
    logic                    full;
    logic                    bypass_show;
    logic                    bypass_take;
    logic                    push_ok;
    logic                    pop_ok;
    logic [2*DATA_WIDTH-1:0] head_data;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass_show = empty & push_in & ~flush_in;
`else
    assign bypass_show = 1'b0;
`endif

    // A bypassed word popped in the same cycle is consumed and never stored.
    assign bypass_take = bypass_show & pop_in;
    assign push_ok     = push_in & ~full & ~bypass_take;
    assign pop_ok      = pop_in & ~empty;

    always_ff @(posedge clock_in) begin
        if (reset_in || flush_in) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_WIDTH + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_WIDTH + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    fetch_buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .clock_in   (clock_in),
        .write_en   (push_ok & ~flush_in & ~reset_in),
        .write_addr (wr_ptr_reg),
        .write_data ({pc_in, instr_in}),
        .read_addr  (rd_ptr_reg),
        .read_data  (head_data)
    );

    // Storage is never reset, so the head word is masked whenever nothing is valid.
    always_comb begin
        pc_out    = '0;
        instr_out = '0;
        if (!empty) begin
            pc_out    = head_data[2*DATA_WIDTH-1:DATA_WIDTH];
            instr_out = head_data[DATA_WIDTH-1:0];
        end else if (bypass_show) begin
            pc_out    = pc_in;
            instr_out = instr_in;
        end
    end

    assign valid_out = ~empty | bypass_show;
    assign full_out  = full;
    assign empty_out = empty;
    assign count_out = count_reg;

endmodule
